// File: rtl/picorv32_mem_dma.sv
// Word-copy DMA initiator on the PicoRV32 native memory bus: copies len words
// from src to dst as strictly alternating read/write handshakes.
module picorv32_mem_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LEN_BITS-1:0] len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_BITS-1:0] words_done,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_e;

  state_e              state_q, state_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [31:0]         hold_q, hold_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                error_q, error_d;

  logic [LEN_BITS-1:0] cnt_inc;
  logic [31:0]         offset;
  logic                abort_seen;

  assign cnt_inc    = cnt_q + LEN_BITS'(1);
  assign offset     = 32'({cnt_q, 2'b00});
  // An abort arriving in the handshake cycle itself still ends the current pair.
  assign abort_seen = abort_q | abort;

  assign error      = error_q;
  assign words_done = cnt_q;

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    hold_d    = hold_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    error_d   = error_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          cnt_d   = '0;
          abort_d = 1'b0;
          error_d = 1'b0;
          if (len == '0) begin
            state_d = FINISH;
          end else if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = src_q + offset;
        abort_d   = abort_seen;
        if (mem_ready) begin
          hold_d  = mem_rdata;
          state_d = WRITE;
        end
      end

      WRITE: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = dst_q + offset;
        mem_wdata = hold_q;
        mem_wstrb = 4'hf;
        abort_d   = abort_seen;
        if (mem_ready) begin
          cnt_d = cnt_inc;
          if ((cnt_inc == len_q) || abort_seen) begin
            error_d = abort_seen;
            state_d = FINISH;
          end else begin
            state_d = READ;
          end
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      hold_q  <= 32'h0;
      len_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_picorv32_mem_dma.sv
// Scoreboard bench for picorv32_mem_dma: a sequential-copy reference model
// predicts every bus handshake and completion; a monitor compares them.
module tb_picorv32_mem_dma;
  localparam int LB = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic          mem_ready = 1'b0;
  logic [31:0]   src_addr, dst_addr;
  logic [31:0]   mem_rdata = 32'h0;
  logic [LB-1:0] len;
  logic          busy, done, error, mem_valid;
  logic [LB-1:0] words_done;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_wstrb;

  always #5 clk = ~clk;

  picorv32_mem_dma #(.LEN_BITS(LB)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .abort(abort), .busy(busy), .done(done),
    .error(error), .words_done(words_done), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } bus_t;
  typedef struct { logic err; logic [LB-1:0] words; int cyc; } fin_t;

  bus_t        exp_bus[$];
  fin_t        exp_fin[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, stall_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5a5a_0000);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5a5a_0000);
  endfunction

  task automatic seed(input logic [31:0] a, input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: holds mem_ready low for stall_n cycles of every request.
  int          wait_cnt = 0;
  bit          stalled = 1'b0;
  logic [31:0] rec_addr, rec_wdata;
  logic [3:0]  rec_wstrb;
  always @(negedge clk) begin
    if (mem_valid) begin
      if (stalled) begin
        check("stable_addr", mem_addr, rec_addr);
        check("stable_wdata", mem_wdata, rec_wdata);
        check("stable_wstrb", 32'(mem_wstrb), 32'(rec_wstrb));
      end
      if (wait_cnt < stall_n) begin
        mem_ready = 1'b0;
        wait_cnt++;
        if (!stalled) begin
          rec_addr  = mem_addr;
          rec_wdata = mem_wdata;
          rec_wstrb = mem_wstrb;
        end
        stalled = 1'b1;
      end else begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        stalled   = 1'b0;
        if (mem_wstrb == 4'h0) mem_rdata = rd_mem(mem_addr);
        else mem[mem_addr] = mem_wdata;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
      stalled   = 1'b0;
    end
  end

  // Monitor: every handshake and every done pops one scoreboard entry.
  bus_t mb;
  fin_t mf;
  always @(negedge clk) begin
    #1;
    if (mem_valid && mem_ready) begin
      if (exp_bus.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_req: addr %h wstrb %h, expected no request", mem_addr, mem_wstrb);
      end else begin
        mb = exp_bus.pop_front();
        check("req_addr", mem_addr, mb.addr);
        check("req_wstrb", 32'(mem_wstrb), 32'(mb.wstrb));
        if (mb.wstrb == 4'hf) check("req_wdata", mem_wdata, mb.wdata);
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_fin.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        mf = exp_fin.pop_front();
        check("done_error", 32'(error), 32'(mf.err));
        check("done_words", 32'(words_done), 32'(mf.words));
        check("done_cycle", 32'(cyc), 32'(mf.cyc));
        check("busy_at_done", 32'(busy), 32'h0);
      end
    end
  end

  // Reference model: a plain sequential loop over ref_mem, called on the
  // stimulus cycle just before start is driven.
  task automatic model(input logic [31:0] s, input logic [31:0] d, input int n,
                       input int abort_at, input int st);
    int          c, k;
    logic [31:0] ra, wa, v;
    c = cyc + 1;
    if (n == 0) begin
      exp_fin.push_back('{1'b0, LB'(0), c});
    end else if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
      exp_fin.push_back('{1'b1, LB'(0), c});
    end else begin
      k = (abort_at >= 0 && abort_at < n) ? abort_at + 1 : n;
      for (int i = 0; i < k; i++) begin
        ra = s + (32'(i) << 2);
        wa = d + (32'(i) << 2);
        v  = rd_ref(ra);
        exp_bus.push_back('{ra, 4'h0, 32'h0});
        exp_bus.push_back('{wa, 4'hf, v});
        ref_mem[wa] = v;
      end
      exp_fin.push_back('{(abort_at >= 0 && abort_at < n), LB'(k), c + 2 * k * (1 + st)});
    end
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int st, input int abort_at, input bit poke);
    int b, prev;
    bit aborted;
    stall_n  = st;
    prev     = done_cnt;
    aborted  = 1'b0;
    model(s, d, n, abort_at, st);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = LB'(n);
    @(negedge clk); #2;
    start    = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    len      = LB'($urandom);
    b = 0;
    while (done_cnt == prev && b < 400) begin
      abort = 1'b0;
      if (abort_at >= 0 && !aborted && mem_valid && mem_wstrb == 4'h0 &&
          mem_addr == s + (32'(abort_at) << 2)) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
      start = poke && b == 3 && (busy || done);
      @(negedge clk); #2;
      b++;
    end
    abort = 1'b0;
    start = 1'b0;
    if (done_cnt == prev) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done within 400 cycles, expected done");
    end
    @(negedge clk); #2;
    check("leftover_reqs", 32'(exp_bus.size()), 32'h0);
    exp_bus.delete();
    exp_fin.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected bench to end");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b;
    logic [31:0] s, d;
    int          n, st, ab;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = 32'h0; dst_addr = 32'h0; len = '0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_valid", 32'(mem_valid), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_words", 32'(words_done), 32'h0);
    reset = 1'b0;
    @(negedge clk); #2;

    // Basic copy, then the same source under 3-cycle backpressure.
    for (int i = 0; i < 4; i++) seed(32'h10 + 32'(4 * i), 32'ha0a0_0000 + 32'(i));
    run_xfer(32'h10, 32'h100, 4, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) check("basic_mem", mem[32'h100 + 32'(4 * i)], 32'ha0a0_0000 + 32'(i));
    check("basic_error", 32'(error), 32'h0);
    check("basic_words", 32'(words_done), 32'h4);
    run_xfer(32'h10, 32'h200, 4, 3, -1, 1'b0);
    for (int i = 0; i < 4; i++) check("bp_mem", mem[32'h200 + 32'(4 * i)], 32'ha0a0_0000 + 32'(i));

    // Degenerate operands.
    run_xfer(32'h10, 32'h300, 0, 0, -1, 1'b0);
    check("len0_error", 32'(error), 32'h0);
    run_xfer(32'h12, 32'h300, 4, 0, -1, 1'b0);
    check("misalign_error", 32'(error), 32'h1);

    // Abort during the read of word 2.
    for (int i = 0; i < 8; i++) seed(32'h400 + 32'(4 * i), 32'hc0de_0000 + 32'(i));
    run_xfer(32'h400, 32'h500, 8, 0, 2, 1'b0);
    check("abort_words", 32'(words_done), 32'h3);
    check("abort_error", 32'(error), 32'h1);
    check("abort_word2", mem[32'h508], 32'hc0de_0002);
    check("abort_word3_untouched", 32'(mem.exists(32'h50c)), 32'h0);

    // Address wrap, then a forward-overlapping copy.
    seed(32'hffff_fff8, 32'h1111_1111);
    seed(32'hffff_fffc, 32'h2222_2222);
    seed(32'h0, 32'h3333_3333);
    run_xfer(32'hffff_fff8, 32'h700, 3, 1, -1, 1'b0);
    check("wrap_word2", mem[32'h708], 32'h3333_3333);
    seed(32'h0, 32'hb000_0000);
    seed(32'h4, 32'hb000_0001);
    seed(32'h8, 32'hb000_0002);
    run_xfer(32'h0, 32'h4, 3, 0, -1, 1'b0);
    for (int i = 1; i < 4; i++) check("overlap_mem", mem[32'(4 * i)], 32'hb000_0000);

    // Reset while the write of word 1 is stalled.
    seed(32'h5000, 32'h5a00_0000);
    seed(32'h5004, 32'h5a00_0001);
    stall_n = 2;
    exp_bus.push_back('{32'h5000, 4'h0, 32'h0});
    exp_bus.push_back('{32'h6000, 4'hf, 32'h5a00_0000});
    exp_bus.push_back('{32'h5004, 4'h0, 32'h0});
    ref_mem[32'h6000] = 32'h5a00_0000;
    start = 1'b1; src_addr = 32'h5000; dst_addr = 32'h6000; len = LB'(4);
    @(negedge clk); #2;
    start = 1'b0;
    b = 0;
    while (!(mem_valid && mem_wstrb == 4'hf && mem_addr == 32'h6004 && !mem_ready) && b < 100) begin
      @(negedge clk); #2;
      b++;
    end
    check("rst_mid_reached", 32'(b < 100), 32'h1);
    reset = 1'b1;
    @(negedge clk); #2;
    reset = 1'b0;
    check("rst_mid_valid", 32'(mem_valid), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_words", 32'(words_done), 32'h0);
    check("rst_mid_leftover", 32'(exp_bus.size()), 32'h0);
    repeat (4) @(negedge clk);
    #2;
    run_xfer(32'h5000, 32'h6000, 2, 0, -1, 1'b0);
    check("rst_restart_words", 32'(words_done), 32'h2);

    // Randomized transfers over a shared, possibly overlapping region.
    for (int a = 32'h8000; a < 32'h8300; a += 4) seed(32'(a), $urandom);
    for (int t = 0; t < 24; t++) begin
      s  = 32'h8000 + 32'($urandom_range(0, 63) * 4);
      d  = 32'h8100 + 32'($urandom_range(0, 63) * 4);
      n  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
      if ($urandom_range(0, 5) == 0) d = d | 32'h2;
      st = $urandom_range(0, 2);
      ab = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
      run_xfer(s, d, n, st, ab, 1'($urandom_range(0, 1)));
    end
    for (int a = 32'h8000; a < 32'h8300; a += 4) check("rand_mem", mem[32'(a)], ref_mem[32'(a)]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_dma.md
# picorv32_mem_dma

Word-copy DMA engine acting as an initiator on the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata). It drives the same bus a memory responder serves, copying `len` 32-bit words from `src_addr` to `dst_addr` one read/write pair at a time. It is used to preload and move memory images in smt2-bmc and simulation benches, and as a second bus initiator for equivalence checks on the memory model.

## Interface
- `LEN_BITS`, 16: width of the word-count operand and the progress counter.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `src_addr`  in  32  source byte address; sampled on accepted start.
- `dst_addr`  in  32  destination byte address; sampled on accepted start.
- `len`  in  LEN_BITS  number of words; sampled on accepted start.
- `abort`  in  1  stop request; honoured at the next handshake boundary.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `done`; held until the next accepted start.
- `words_done`  out  LEN_BITS  words fully copied (write handshake complete).
- `mem_valid`  out  1  request valid.
- `mem_ready`  in  1  responder accepts; the transfer completes when `mem_valid && mem_ready`.
- `mem_addr`  out  32  word-aligned byte address.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  4'h0 for a read, 4'hf for a write.
- `mem_rdata`  in  32  read data; sampled in the read handshake cycle.

## Operation
- States: IDLE, READ, WRITE, FINISH.
- Reset values: state IDLE. `busy`, `done`, `error`, `mem_valid` are 0. `mem_addr`, `mem_wdata`, `words_done` are 0. `mem_wstrb` is 4'h0.
- IDLE + `start`:
  - Latch the operands, clear `words_done` and `error`.
  - If `len == 0`, go to FINISH with `error` = 0.
  - If `src_addr[1:0]` or `dst_addr[1:0]` is nonzero, go to FINISH with `error` = 1. No bus transaction is issued in either case.
  - Otherwise go to READ.
- `start` outside IDLE is ignored.
- READ:
  - Drive `mem_valid` = 1, `mem_addr` = src + 4*i, `mem_wstrb` = 0.
  - On handshake, capture `mem_rdata` into a holding register and go to WRITE.
- WRITE:
  - Drive `mem_valid` = 1, `mem_addr` = dst + 4*i, `mem_wdata` = holding register, `mem_wstrb` = 4'hf.
  - On handshake, increment i and `words_done`.
  - Go to FINISH if i == len or abort is pending; otherwise go to READ.
- FINISH: `done` = 1 for one cycle, `busy` = 0, then IDLE.
- Request stability rule: once `mem_valid` is high, `mem_addr`, `mem_wdata` and `mem_wstrb` are stable and `mem_valid` stays high until the handshake. `mem_valid` is never withdrawn without a handshake, except by `reset`.
- Abort:
  - `abort` in READ or WRITE sets a sticky pending flag.
  - The engine finishes the current pair (read, then its write) and ends at that write handshake with `error` = 1.
  - `abort` in IDLE or FINISH is ignored.
- Address arithmetic: 32-bit, modulo 2^32. src + 4*i wraps past 32'hffff_fffc to 0 with no error.
- Overlapping ranges: a strictly forward word-by-word copy. The result equals a sequential loop from i = 0 upward.
- Reset mid-operation: IDLE on the next edge, `mem_valid` low, no `done` pulse, `words_done` cleared.

## Timing
- `start` accepted at edge t:
  - `busy` and `mem_valid` are high from cycle t+1.
  - `mem_addr` = src in cycle t+1.
- With `mem_ready` tied high:
  - Read of word i completes in cycle t+1+2i; write of word i in cycle t+2+2i.
  - `done` in cycle t+1+2N.
  - Throughput is 2 cycles per word; no idle cycle between pairs.
- Each cycle `mem_ready` is low while `mem_valid` is high adds one cycle; request fields stay unchanged.
- `len == 0` or misaligned: `done` in cycle t+1, `busy` never asserted, `mem_valid` never asserted.
- `words_done` updates the cycle after each write handshake and equals `len` when a non-aborted `done` fires.
- A `start` in the `done` cycle is ignored; the earliest accepted restart is the cycle after `done`.

## Test plan
- **Basic copy:** memory words 0x10..0x1c = A0..A3, src = 0x10, dst = 0x100, len = 4, `mem_ready` = 1 -> words 0x100..0x10c = A0..A3, `done` at t+9, `error` = 0, `words_done` = 4, 8 handshakes alternating wstrb 0/f.
- **Backpressure:** same transfer, `mem_ready` low for 3 cycles during each request -> request fields stable while waiting, identical memory result, `done` delayed by 24 cycles.
- **Degenerate operands:** len = 0 -> `done` at t+1, `error` = 0, no `mem_valid`. src = 0x12 -> `done` at t+1, `error` = 1, no `mem_valid`.
- **Abort:** len = 8, `abort` pulsed during the read of word 2 -> words 0..2 copied, `done` with `error` = 1, `words_done` = 3, no further requests.
- **Wrap and overlap:** src = 0xffff_fff8, len = 3 -> reads at 0xffff_fff8, 0xffff_fffc, 0x0. Separately, src = 0x0, dst = 0x4, len = 3 over B0,B1,B2 -> words 0x4..0xc = B0,B0,B0.
- **Reset mid-copy:** `reset` during the write of word 1 -> `mem_valid` 0 next cycle, no `done`, a new `start` then runs normally.
